// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_t       : controller states (IDLE, CALC, DONE)
//   DIV_DEFAULT_WIDTH : default operand/result width
//   div_cnt_width()   : width of the iteration down-counter for a given operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_DEFAULT_WIDTH = 8;

    // One extra bit so the counter can be loaded with WIDTH itself.
    function automatic int div_cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/cla_subtractor.sv
// N-bit subtractor computing a - b as a + ~b + 1 with a full carry look-ahead.
// Ports:
//   a, b   : N-bit unsigned operands
//   diff   : N-bit difference (a - b modulo 2^N)
//   borrow : 1 when b > a (inverse of the adder carry-out)
module cla_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N-1:0] b_n;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic         term;
    logic         prop;

    assign b_n = ~b;
    assign g   = a & b_n;
    assign p   = a ^ b_n;

    // Each carry is formed directly from generate/propagate terms and the
    // carry-in (1 for the +1 of two's complement), never from a lower carry:
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
    always_comb begin
        c    = '0;
        term = 1'b0;
        prop = 1'b0;
        c[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            term = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prop & g[j]);
                prop = prop & p[j];
            end
            term     = term | prop;
            c[i + 1] = term;
        end
    end

    assign diff   = p ^ c[N-1:0];
    assign borrow = ~c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begin a division (only honoured in IDLE)
//   dividend, divisor    : operands, captured when start is accepted
//   busy                 : high while iterating
//   done                 : one-cycle pulse when results are valid
//   quotient, remainder  : registered results, held until the next done
//   div_by_zero          : set with the results of a zero-divisor request
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; zero divisor skips straight to DONE
// CALC  | WIDTH shift/trial-subtract iterations under a down-counter
// DONE  | results valid, done pulses for one cycle, start ignored
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = div_cnt_width(WIDTH);

    div_state_t       state_q;
    div_state_t       state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] next_part;
    logic [WIDTH-1:0] next_work;
    logic             accept;
    logic             calc;
    logic             last_iter;
    logic             div_zero_in;
    logic             unused_trial_msb;

    // work_q starts as the dividend and shifts left each iteration: its MSB
    // feeds the partial remainder while quotient bits enter at the LSB, so
    // after WIDTH iterations it holds the quotient.
    assign shifted = {part_q, work_q[WIDTH-1]};

    cla_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .a      (shifted),
        .b      ({1'b0, dvsr_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    // A successful trial is always below the divisor, so its MSB is zero.
    assign unused_trial_msb = trial[WIDTH];
    assign next_part        = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign next_work        = {work_q[WIDTH-2:0], ~borrow};
    assign div_zero_in      = (divisor == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        calc      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = div_zero_in ? DONE : CALC;
                end
            end
            CALC: begin
                calc = 1'b1;
                if (cnt_q == CW'(1)) begin
                    last_iter = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = calc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dvsr_q      <= '0;
            work_q      <= '0;
            part_q      <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvsr_q <= divisor;
            work_q <= dividend;
            part_q <= '0;
            if (div_zero_in) begin
                cnt_q       <= '0;
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                cnt_q <= CW'(WIDTH);
            end
        end else if (calc) begin
            part_q <= next_part;
            work_q <= next_work;
            cnt_q  <= cnt_q - CW'(1);
            if (last_iter) begin
                quotient    <= next_work;
                remainder   <= next_part;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks;
    int n_errors;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Issue one division and follow it to done. Cycle index 1 is the cycle
    // after the accepting edge. Operands are scrambled right after acceptance.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int nbusy, output int done_at);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        nbusy    = 0;
        done_at  = -1;
        q        = '0;
        r        = '0;
        z        = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                done_at = i;
                q       = quotient;
                r       = remainder;
                z       = div_by_zero;
                break;
            end
        end
    endtask

    initial begin
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           nb;
        int           da;
        int           ndone;
        int           first;
        int           second;
        logic [W-1:0] q2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0]  = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   z: 1'b0};
        vecs[1]  = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0};
        vecs[2]  = '{a: 8'd3,   b: 8'd10,  q: 8'd0,   r: 8'd3,   z: 1'b0};
        vecs[3]  = '{a: 8'd5,   b: 8'd0,   q: 8'd255, r: 8'd5,   z: 1'b1};
        vecs[4]  = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,   z: 1'b0};
        vecs[5]  = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   z: 1'b0};
        vecs[6]  = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0};
        vecs[7]  = '{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254, z: 1'b0};
        vecs[8]  = '{a: 8'd128, b: 8'd16,  q: 8'd8,   r: 8'd0,   z: 1'b0};
        vecs[9]  = '{a: 8'd77,  b: 8'd13,  q: 8'd5,   r: 8'd12,  z: 1'b0};
        vecs[10] = '{a: 8'd0,   b: 8'd0,   q: 8'd255, r: 8'd0,   z: 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", {24'd0, quotient}, 32'd0);
        chk("rst_remainder", {24'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[k]) begin
            do_div(vecs[k].a, vecs[k].b, q, r, z, nb, da);
            chk($sformatf("vec%0d_quotient", k), {24'd0, q}, {24'd0, vecs[k].q});
            chk($sformatf("vec%0d_remainder", k), {24'd0, r}, {24'd0, vecs[k].r});
            chk($sformatf("vec%0d_dbz", k), {31'd0, z}, {31'd0, vecs[k].z});
            chk($sformatf("vec%0d_done_cycle", k), da, vecs[k].z ? 32'd1 : 32'(W + 1));
            chk($sformatf("vec%0d_busy_cycles", k), nb, vecs[k].z ? 32'd0 : 32'(W));
        end

        // Results hold in IDLE after done
        @(negedge clk);
        chk("hold_quotient", {24'd0, quotient}, 32'd255);
        chk("hold_dbz", {31'd0, div_by_zero}, 32'd1);

        // start during CALC is ignored and not queued
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        q     = '0;
        r     = '0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                q = quotient;
                r = remainder;
            end
            if (i == 3) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            if (i == 4) start = 1'b0;
        end
        chk("ignore_start_done_count", ndone, 32'd1);
        chk("ignore_start_quotient", {24'd0, q}, 32'd22);
        chk("ignore_start_remainder", {24'd0, r}, 32'd2);

        // start held high through DONE: one division per W+2 cycles
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        first    = -1;
        second   = -1;
        q2       = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) first = i;
                else if (second < 0) begin
                    second = i;
                    q2     = quotient;
                end
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_first_done", first, 32'(W + 1));
        chk("b2b_spacing", second - first, 32'(W + 2));
        chk("b2b_quotient", {24'd0, q2}, 32'd14);

        // Reset in cycle 4 of CALC
        @(negedge clk);
        dividend = 8'd60;
        divisor  = 8'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_quotient", {24'd0, quotient}, 32'd0);
        chk("midrst_remainder", {24'd0, remainder}, 32'd0);
        chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("midrst_no_activity", ndone, 32'd0);
        do_div(8'd60, 8'd4, q, r, z, nb, da);
        chk("after_rst_quotient", {24'd0, q}, 32'd15);
        chk("after_rst_remainder", {24'd0, r}, 32'd0);
        chk("after_rst_done_cycle", da, 32'(W + 1));

        // Random sweep against a reference division
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(1, 255));
            do_div(ra, rb, q, r, z, nb, da);
            chk($sformatf("rand_q %0d/%0d", ra, rb), {24'd0, q}, {24'd0, ra / rb});
            chk($sformatf("rand_r %0d/%0d", ra, rb), {24'd0, r}, {24'd0, ra % rb});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
